// File: rtl/seq_1010_pkg.sv
// Shared types and constants for the seq_1010_tx serial framer.
// Optional parity bit is enabled by defining SEQ_1010_TX_PARITY_EN.
package seq_1010_pkg;

    // Number of sync bits sent ahead of every payload word.
    localparam int PRE_LEN = 4;

    // Sync pattern recognised by the downstream 1010 detector.
    localparam logic [PRE_LEN-1:0] PREAMBLE_DEFAULT = 4'b1010;

    // Frame phases; PAR only has a case arm when the parity bit is built in.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        DATA = 3'd2,
        PAR  = 3'd3,
        GAP  = 3'd4
    } state_e;

    // Largest of three sizes, used to size the shared bit counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/seq_1010_tx_piso_shift.sv
// Parallel-in, serial-out shift register presenting its MSB first.
// A load takes priority over a shift in the same cycle.
module piso_shift #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         msb
);

    logic [W-1:0] sreg_q;
    logic [W-1:0] sreg_d;

    // Next register contents: fresh word on load, move one bit toward MSB on shift.
    always_comb begin
        sreg_d = sreg_q;
        if (load) begin
            sreg_d = din;
        end else if (shift) begin
            sreg_d = sreg_q << 1;
        end
    end

    // Register with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sreg_q <= '0;
        end else begin
            sreg_q <= sreg_d;
        end
    end

    assign msb = sreg_q[W-1];

endmodule

// File: rtl/seq_1010_tx.sv
// Serial framer: 1010 preamble, payload MSB-first, then a zero gap.
// All outputs are registered, so each one reflects the phase the FSM has just entered.
// Define SEQ_1010_TX_PARITY_EN to insert an even-parity bit after the payload.
module seq_1010_tx
    import seq_1010_pkg::*;
#(
    parameter int                 DATA_W   = 8,
    parameter logic [PRE_LEN-1:0] PREAMBLE = PREAMBLE_DEFAULT,
    parameter int                 GAP_LEN  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid,
    output logic              ready,
    output logic              o,
    output logic              busy,
    output logic              done
);

    localparam int CNT_MAX = max3(PRE_LEN, DATA_W, GAP_LEN);
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_LEN - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_LEN - 1);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_dec;
    logic             o_q;
    logic             o_d;
    logic             ready_q;
    logic             ready_d;
    logic             busy_q;
    logic             busy_d;
    logic             done_q;
    logic             done_d;
    logic             sr_load;
    logic             sr_shift;
    logic             sr_msb;
`ifdef SEQ_1010_TX_PARITY_EN
    logic             par_q;
    logic             par_d;
`endif

    assign cnt_dec = cnt_q - 1'b1;

    piso_shift #(
        .W (DATA_W)
    ) u_payload (
        .clk   (clk),
        .rst   (rst),
        .load  (sr_load),
        .shift (sr_shift),
        .din   (data_in),
        .msb   (sr_msb)
    );

    // Next-state, counter and next-output logic; o_d is the bit for the phase being entered.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        o_d      = 1'b0;
        done_d   = 1'b0;
        sr_load  = 1'b0;
        sr_shift = 1'b0;
`ifdef SEQ_1010_TX_PARITY_EN
        par_d    = par_q;
`endif

        case (state_q)
            IDLE: begin
                if (valid && ready_q) begin
                    state_d = PRE;
                    cnt_d   = PRE_LAST;
                    o_d     = PREAMBLE[PRE_LEN-1];
                    sr_load = 1'b1;
`ifdef SEQ_1010_TX_PARITY_EN
                    par_d   = ^data_in;
`endif
                end
            end

            PRE: begin
                if (cnt_q == '0) begin
                    state_d  = DATA;
                    cnt_d    = DATA_LAST;
                    o_d      = sr_msb;
                    sr_shift = 1'b1;
                end else begin
                    cnt_d = cnt_dec;
                    o_d   = PREAMBLE[cnt_dec[1:0]];
                end
            end

            DATA: begin
                if (cnt_q == '0) begin
                    cnt_d = GAP_LAST;
`ifdef SEQ_1010_TX_PARITY_EN
                    state_d = PAR;
                    o_d     = par_q;
`else
                    state_d = GAP;
                    done_d  = 1'b1;
`endif
                end else begin
                    cnt_d    = cnt_dec;
                    o_d      = sr_msb;
                    sr_shift = 1'b1;
                end
            end

`ifdef SEQ_1010_TX_PARITY_EN
            PAR: begin
                state_d = GAP;
                done_d  = 1'b1;
            end
`endif

            GAP: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_dec;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    // Single state/counter/output register bank with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            o_q     <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SEQ_1010_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            o_q     <= o_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SEQ_1010_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign o     = o_q;
    assign ready = ready_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_seq_1010_tx.sv
// Self-checking bench for seq_1010_tx: frame-level reference model plus directed literal checks.
module tb_seq_1010_tx;

    localparam int DATA_W  = 8;
    localparam int GAP_LEN = 2;
`ifdef SEQ_1010_TX_PARITY_EN
    localparam int PAR_LEN = 1;
`else
    localparam int PAR_LEN = 0;
`endif
    localparam int FL = 4 + DATA_W + PAR_LEN + GAP_LEN;
    localparam logic [3:0] SYNC = 4'b1010;

    logic              clk = 1'b0;
    logic              rst;
    logic              valid;
    logic [DATA_W-1:0] data_in;
    logic              ready;
    logic              o;
    logic              busy;
    logic              done;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    logic log_o[$];
    logic log_done[$];
    logic log_ready[$];
    logic log_busy[$];

    logic mq_o[$];
    logic mq_done[$];

    seq_1010_tx #(
        .DATA_W   (DATA_W),
        .PREAMBLE (4'b1010),
        .GAP_LEN  (GAP_LEN)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .data_in (data_in),
        .valid   (valid),
        .ready   (ready),
        .o       (o),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Compare one value against its expectation and report on mismatch.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs shortly after the rising edge.
    task automatic applyStimulus(input logic r, input logic v, input logic [DATA_W-1:0] d);
        @(posedge clk);
        #2;
        rst     = r;
        valid   = v;
        data_in = d;
    endtask

    // Serial bits from the log, packed MSB-first.
    function automatic logic [31:0] bitsAt(input int start, input int n);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r = {r[30:0], log_o[start+i]};
        return r;
    endfunction

    function automatic logic [31:0] doneAt(input int start, input int n);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r = {r[30:0], log_done[start+i]};
        return r;
    endfunction

    // Position (1-based) at which an overlapping 1010 detector first sees its pattern.
    function automatic int firstFire(input int start, input int n);
        logic [3:0] sh;
        sh = '0;
        for (int i = 0; i < n; i++) begin
            sh = {sh[2:0], log_o[start+i]};
            if (sh == 4'b1010) return i + 1;
        end
        return -1;
    endfunction

    // Frame model: a queue of the serial bits and done flags still owed for the current frame.
    always @(posedge clk) begin
        logic was_idle;
        was_idle = (mq_o.size() == 0);
        if (rst !== 1'b1) begin
            mq_o.delete();
            mq_done.delete();
        end else if (!was_idle) begin
            void'(mq_o.pop_front());
            void'(mq_done.pop_front());
        end else if (valid === 1'b1) begin
            for (int i = 3; i >= 0; i--) begin
                mq_o.push_back(SYNC[i]);
                mq_done.push_back(1'b0);
            end
            for (int i = DATA_W - 1; i >= 0; i--) begin
                mq_o.push_back(data_in[i]);
                mq_done.push_back(1'b0);
            end
`ifdef SEQ_1010_TX_PARITY_EN
            mq_o.push_back(^data_in);
            mq_done.push_back(1'b0);
`endif
            for (int g = 0; g < GAP_LEN; g++) begin
                mq_o.push_back(1'b0);
                mq_done.push_back(g == 0);
            end
        end
    end

    // Mid-cycle logging and per-cycle comparison against the frame model.
    always @(negedge clk) begin
        log_o.push_back(o);
        log_done.push_back(done);
        log_ready.push_back(ready);
        log_busy.push_back(busy);
        if (check_en) begin
            if (mq_o.size() > 0) begin
                checkOutput("cyc_o",     32'(o),     32'(mq_o[0]));
                checkOutput("cyc_done",  32'(done),  32'(mq_done[0]));
                checkOutput("cyc_busy",  32'(busy),  32'd1);
                checkOutput("cyc_ready", 32'(ready), 32'd0);
            end else begin
                checkOutput("cyc_o",     32'(o),     32'd0);
                checkOutput("cyc_done",  32'(done),  32'd0);
                checkOutput("cyc_busy",  32'(busy),  32'd0);
                checkOutput("cyc_ready", 32'(ready), 32'd1);
            end
        end
    end

    initial begin
        int k;
        rst     = 1'b0;
        valid   = 1'b0;
        data_in = '0;
        @(posedge clk);
        #2;
        check_en = 1'b1;

        // Reset for two cycles, then ten idle cycles.
        applyStimulus(1'b0, 1'b0, 8'h00);
        repeat (10) applyStimulus(1'b1, 1'b0, 8'h00);
        k = log_o.size();
        checkOutput("idle_o",     32'(log_o[k-2]),     32'd0);
        checkOutput("idle_ready", 32'(log_ready[k-2]), 32'd1);
        checkOutput("idle_busy",  32'(log_busy[k-2]),  32'd0);
        checkOutput("idle_done",  32'(log_done[k-2]),  32'd0);

        // Single A5 frame.
        applyStimulus(1'b1, 1'b1, 8'hA5);
        k = log_o.size();
        repeat (FL + 3) applyStimulus(1'b1, 1'b0, 8'h00);
`ifdef SEQ_1010_TX_PARITY_EN
        checkOutput("a5_bits", bitsAt(k + 1, FL),     32'b101010100101000);
        checkOutput("a5_done", doneAt(k + 1, FL + 1), 32'b0000000000000100);
`else
        checkOutput("a5_bits", bitsAt(k + 1, FL),     32'b10101010010100);
        checkOutput("a5_done", doneAt(k + 1, FL + 1), 32'b000000000000100);
`endif
        checkOutput("a5_ready_last_gap", 32'(log_ready[k+FL]),   32'd0);
        checkOutput("a5_ready_back",     32'(log_ready[k+FL+1]), 32'd1);
        checkOutput("a5_busy_first",     32'(log_busy[k+1]),     32'd1);
        checkOutput("a5_detector",       32'(firstFire(k + 1, FL)), 32'd4);

        // Back-to-back: valid held high, FF then 00.
        applyStimulus(1'b1, 1'b1, 8'hFF);
        k = log_o.size();
        repeat (FL + 1) applyStimulus(1'b1, 1'b1, 8'h00);
        repeat (FL + 3) applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("b2b_payload1", bitsAt(k + 5, 8), 32'h000000FF);
        checkOutput("b2b_spacing",  bitsAt(k + FL - GAP_LEN + 1, GAP_LEN + 1), 32'd0);
        checkOutput("b2b_idle_rdy", 32'(log_ready[k+FL+1]), 32'd1);
        checkOutput("b2b_frame2",   bitsAt(k + FL + 2, 12), 32'b101000000000);

        // Reset during payload bit 3.
        applyStimulus(1'b1, 1'b1, 8'h3C);
        k = log_o.size();
        repeat (6) applyStimulus(1'b1, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b0, 8'h00);
        repeat (10) applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("rst_partial", bitsAt(k + 5, 3), 32'b001);
        checkOutput("rst_o",       32'(log_o[k+8]),     32'd0);
        checkOutput("rst_ready",   32'(log_ready[k+8]), 32'd1);
        checkOutput("rst_busy",    32'(log_busy[k+8]),  32'd0);
        checkOutput("rst_no_done", doneAt(k + 1, 16),   32'd0);

        // Valid pulse during preamble is ignored.
        applyStimulus(1'b1, 1'b1, 8'h01);
        k = log_o.size();
        applyStimulus(1'b1, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b1, 8'hEE);
        applyStimulus(1'b1, 1'b0, 8'h00);
        repeat (FL + 3) applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("busy_payload", bitsAt(k + 5, 8), 32'h00000001);
        checkOutput("busy_no_refire", bitsAt(k + FL + 1, 2), 32'd0);

`ifdef SEQ_1010_TX_PARITY_EN
        // Parity bit of 07 is 1 and done moves one cycle later.
        applyStimulus(1'b1, 1'b1, 8'h07);
        k = log_o.size();
        repeat (FL + 3) applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("par_bit",     32'(log_o[k+13]),     32'd1);
        checkOutput("par_done_13", 32'(log_done[k+13]),  32'd0);
        checkOutput("par_done_14", 32'(log_done[k+14]),  32'd1);
        checkOutput("par_ready15", 32'(log_ready[k+15]), 32'd0);
        checkOutput("par_ready16", 32'(log_ready[k+16]), 32'd1);
`endif

        // Randomized traffic with occasional resets, checked by the frame model.
        repeat (3000) begin
            logic r;
            logic v;
            r = ($urandom_range(0, 199) != 0);
            v = ($urandom_range(0, 2) != 0);
            applyStimulus(r, v, 8'($urandom));
        end
        repeat (FL + 2) applyStimulus(1'b1, 1'b0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_1010_tx.md
Name: seq_1010_tx

Overview:
- Serial transmitter that drives a 1-bit line monitored by the Moore "1010" overlapping detector.
- Accepts a parallel word over a valid/ready handshake.
- Emits a fixed 4-bit sync preamble 1010, then the word MSB-first, then a quiet gap of zeros.
- Serial output is registered (Moore style); one bit per clock.

Parameters:
- DATA_W, 8, width of the parallel payload word.
- PREAMBLE, 4'b1010, sync pattern sent MSB-first before every word.
- GAP_LEN, 2, number of idle (0) bit-times after each frame; legal range 1..15.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset.
- data_in  input  DATA_W  payload word; sampled only on accept.
- valid  input  1  upstream has a word.
- ready  output  1  block can accept; high only in IDLE.
- o  output  1  serial line, registered.
- busy  output  1  high from the cycle after accept until return to IDLE.
- done  output  1  one-cycle pulse in the first GAP cycle of each frame.

Behaviour:
- Reset (rst=0 at a rising edge) forces state=IDLE, o=0, ready=1, busy=0, done=0, and clears the shift register and counters.
  - Reset mid-frame aborts the frame immediately; the partial word is lost and no done is issued.
- States: IDLE, PRE, DATA, GAP (plus PAR when PARITY_EN is defined).
- IDLE:
  - o=0, ready=1.
  - Accept = valid && ready at an edge: data_in is latched and the bit counter is loaded with 3.
  - Next state is PRE; the next cycle o=PREAMBLE[3].
  - valid without acceptance has no effect; valid while not in IDLE is ignored (ready=0).
- PRE:
  - o=PREAMBLE[cnt] for 4 cycles (cnt 3..0).
  - On cnt==0: go to DATA and load cnt=DATA_W-1.
- DATA:
  - o=word[cnt] for DATA_W cycles, MSB first.
  - On cnt==0: go to GAP (or PAR) and load cnt=GAP_LEN-1.
- GAP:
  - o=0 for GAP_LEN cycles; done=1 in the first GAP cycle only.
  - On cnt==0: go to IDLE.
- Frame length is 4+DATA_W+GAP_LEN cycles from the first preamble bit to the first IDLE cycle (14 with defaults).
- Back-to-back: a word presented with valid held high is accepted in the first IDLE cycle. Inter-frame spacing is therefore one IDLE cycle (o=0) plus the gap.
- Counters are $clog2 sized to the largest of 4, DATA_W, GAP_LEN; no wrap-around is reachable.
- An undefined state encoding recovers to IDLE on the next edge with o=0.
- Payload bits are not scrambled. A payload containing 1010 can also trigger the downstream detector; framing is the consumer's concern.

Optional Feature:
- SEQ_1010_TX_PARITY_EN
  - Defined: a PAR state follows DATA for one cycle, driving o = XOR of the latched word (even parity). done stays in the first GAP cycle, and the frame lengthens by 1 cycle.
  - Undefined: there is no PAR state, and DATA goes directly to GAP.

Decomposition:
- Package seq_1010_pkg holds:
  - the state typedef (IDLE, PRE, DATA, PAR, GAP);
  - the PREAMBLE_DEFAULT constant 4'b1010;
  - a localparam for the preamble length, 4.
- One natural sub-module, piso_shift: a parallel-load, MSB-first shift register with load/shift enables, used for the payload.
- The FSM and counters stay in seq_1010_tx.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, then release, valid=0 for 10 cycles -> o=0, ready=1, busy=0, done=0 throughout.
- Single frame: data_in=8'hA5, valid pulsed 1 cycle in IDLE -> o = 1010 then 10100101 then 00, done high exactly at cycle 13 after accept, ready back to 1 at cycle 15. A loopback detector fires at least at preamble bit 4.
- Back-to-back: valid held high with 8'hFF then 8'h00 -> two frames separated by exactly GAP_LEN+1 zero cycles; second frame payload 00000000.
- Reset mid-frame: accept 8'h3C, assert rst=0 during DATA cycle 3 -> next cycle o=0, ready=1, busy=0, and done never pulses for that frame.
- Valid during busy: accept 8'h01, pulse valid with 8'hEE during PRE -> 8'hEE is ignored and the payload sent is 00000001.
- Parity (SEQ_1010_TX_PARITY_EN): data_in=8'h07 -> 1 bit after the payload is 1; frame is 15 cycles; done is in the first GAP cycle.
